fetch_pc_unit: RTL and testbench

- Parametrised next-generation fetch stage for the 5-stage MIPS pipeline.
- Owns the PC and issues instruction fetches over a req/addr_ok/data_ok SRAM-like handshake, with one transaction in flight.
- Presents fetched instructions to decode with a valid/allowin handshake.
- Applies flush redirects (exception, eret) and delayed branch/jump redirects, including cancellation of in-flight fetches and their returned data.

---
 rtl/fetch_pc_unit_pkg.sv | 17 +
 rtl/fetch_pc_unit_redirect_arb.sv | 37 +++
 rtl/fetch_pc_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pkg: shared types and default vectors for the fetch PC unit.
//   fetch_state_t   - fetch FSM state encoding
//   DEF_RESET_ADDR  - default PC after reset
//   DEF_EXCEPT_ADDR - default exception vector
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_ADDR  = 32'hbfc00000;
    localparam logic [31:0] DEF_EXCEPT_ADDR = 32'hbfc00380;

endpackage

// File: rtl/fetch_pc_unit_redirect_arb.sv
// pc_redirect_arb: combinational redirect priority, ex > eret > br > j.
// Ports:
//   ex_flush, eret_flush, epc              - flush requests and eret target
//   br_taken, br_target                    - branch redirect
//   j_taken, jsrc, jr_target, j_target     - jump redirect and source select
//   flush, flush_tgt                       - resolved flush and its target
//   br_hit, br_tgt_sel                     - branch/jump accepted (no flush) and its target
module pc_redirect_arb
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    EXCEPT_ADDR = ADDR_W'(DEF_EXCEPT_ADDR)
) (
    input  logic              ex_flush,
    input  logic              eret_flush,
    input  logic [ADDR_W-1:0] epc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              j_taken,
    input  logic              jsrc,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] j_target,
    output logic              flush,
    output logic [ADDR_W-1:0] flush_tgt,
    output logic              br_hit,
    output logic [ADDR_W-1:0] br_tgt_sel
);

    always_comb begin
        flush      = ex_flush | eret_flush;
        flush_tgt  = ex_flush ? EXCEPT_ADDR : epc;
        // A branch/jump coincident with a flush belongs to a squashed instruction.
        br_hit     = ~flush & (br_taken | j_taken);
        br_tgt_sel = br_taken ? br_target : (jsrc ? jr_target : j_target);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch stage owning the PC. Issues one fetch at a time over a
// req/addr_ok/data_ok handshake and presents instructions to decode with
// valid/allowin. Handles flush redirects (exception, eret) and delayed
// branch/jump redirects, cancelling in-flight fetches when needed.
// Ports:
//   clk, resetn                      - clock, async active-low reset
//   ex_flush, eret_flush, epc        - flush redirect inputs
//   br_taken, br_target              - branch redirect
//   j_taken, jsrc, jr_target, j_target - jump redirect
//   inst_req, inst_addr              - fetch request/address
//   inst_addr_ok, inst_data_ok, inst_rdata - memory responses
//   ds_allowin                       - decode ready
//   fs_valid, fs_pc, fs_inst         - presented instruction
//   fs_adel                          - fetch address misaligned
//   fs_abnormal                      - first instruction after a flush
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(DEF_RESET_ADDR),
    parameter logic [ADDR_W-1:0] EXCEPT_ADDR = ADDR_W'(DEF_EXCEPT_ADDR),
    parameter int unsigned       INST_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_flush,
    input  logic              eret_flush,
    input  logic [ADDR_W-1:0] epc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              j_taken,
    input  logic              jsrc,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] j_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              ds_allowin,
    output logic              fs_valid,
    output logic [ADDR_W-1:0] fs_pc,
    output logic [INST_W-1:0] fs_inst,
    output logic              fs_adel,
    output logic              fs_abnormal
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] cancel_tgt;
    logic              br_pend;
    logic              cancel;

    logic              flush;
    logic [ADDR_W-1:0] flush_tgt;
    logic              br_hit;
    logic [ADDR_W-1:0] br_tgt_sel;
    logic              pc_aligned;
    logic [ADDR_W-1:0] next_pc;

    pc_redirect_arb #(
        .ADDR_W      (ADDR_W),
        .EXCEPT_ADDR (EXCEPT_ADDR)
    ) u_arb (
        .ex_flush   (ex_flush),
        .eret_flush (eret_flush),
        .epc        (epc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .j_taken    (j_taken),
        .jsrc       (jsrc),
        .jr_target  (jr_target),
        .j_target   (j_target),
        .flush      (flush),
        .flush_tgt  (flush_tgt),
        .br_hit     (br_hit),
        .br_tgt_sel (br_tgt_sel)
    );

    assign pc_aligned = (pc[1:0] == 2'b00);
    assign inst_req   = (state == S_REQ) && pc_aligned;
    assign inst_addr  = pc;
    assign fs_valid   = (state == S_HOLD) && !flush;

    // A branch arriving during the handoff of its delay slot redirects immediately.
    always_comb begin
        next_pc = pc + ADDR_W'(4);
        if (br_hit)
            next_pc = br_tgt_sel;
        else if (br_pend)
            next_pc = br_tgt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_BOOT;
            pc          <= RESET_ADDR;
            br_tgt      <= '0;
            cancel_tgt  <= '0;
            br_pend     <= 1'b0;
            cancel      <= 1'b0;
            fs_pc       <= '0;
            fs_inst     <= '0;
            fs_adel     <= 1'b0;
            fs_abnormal <= 1'b0;
        end else begin
            // Branch latch first; flush and handoff below override br_pend.
            if (br_hit) begin
                br_pend <= 1'b1;
                br_tgt  <= br_tgt_sel;
            end
            if (flush) begin
                br_pend     <= 1'b0;
                fs_abnormal <= 1'b1;
            end

            case (state)
                S_BOOT: state <= S_REQ;

                S_REQ: begin
                    if (!pc_aligned) begin
                        // Nothing is on the bus, so a flush simply retargets.
                        if (flush) begin
                            pc <= flush_tgt;
                        end else begin
                            fs_pc   <= pc;
                            fs_inst <= '0;
                            fs_adel <= 1'b1;
                            state   <= S_HOLD;
                        end
                    end else begin
                        // The request must complete unchanged; remember to drop its data.
                        if (flush) begin
                            cancel     <= 1'b1;
                            cancel_tgt <= flush_tgt;
                        end
                        if (inst_addr_ok)
                            state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel || flush) begin
                            pc     <= flush ? flush_tgt : cancel_tgt;
                            cancel <= 1'b0;
                            state  <= S_REQ;
                        end else begin
                            fs_pc   <= pc;
                            fs_inst <= inst_rdata;
                            fs_adel <= 1'b0;
                            state   <= S_HOLD;
                        end
                    end else if (flush) begin
                        cancel     <= 1'b1;
                        cancel_tgt <= flush_tgt;
                    end
                end

                S_HOLD: begin
                    if (flush) begin
                        pc      <= flush_tgt;
                        fs_adel <= 1'b0;
                        state   <= S_REQ;
                    end else if (ds_allowin) begin
                        pc          <= next_pc;
                        br_pend     <= 1'b0;
                        fs_adel     <= 1'b0;
                        fs_abnormal <= 1'b0;
                        state       <= S_REQ;
                    end
                end

                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_flush, eret_flush, br_taken, j_taken, jsrc;
    logic [31:0] epc, br_target, jr_target, j_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        ds_allowin;
    logic        fs_valid, fs_adel, fs_abnormal;
    logic [31:0] fs_pc, fs_inst;

    int checks = 0;
    int errors = 0;

    int          data_lat = 0;
    bit          resp_wait = 0;
    int          resp_cnt = 0;
    int          req_age = 0;
    logic [31:0] resp_addr = '0;

    logic [31:0] acc_q[$];
    logic [31:0] hpc_q[$];
    logic [31:0] hinst_q[$];
    bit          habn_q[$];
    int          odd_req = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_flush     (ex_flush),
        .eret_flush   (eret_flush),
        .epc          (epc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .j_taken      (j_taken),
        .jsrc         (jsrc),
        .jr_target    (jr_target),
        .j_target     (j_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .ds_allowin   (ds_allowin),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst),
        .fs_adel      (fs_adel),
        .fs_abnormal  (fs_abnormal)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: addr_ok one cycle after a request appears, data_ok data_lat cycles later.
    always @(posedge clk) begin
        #1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (!resetn) begin
            resp_wait = 0;
            req_age   = 0;
        end else if (resp_wait) begin
            if (resp_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = inst_of(resp_addr);
                resp_wait    = 0;
            end else begin
                resp_cnt = resp_cnt - 1;
            end
        end else if (inst_req) begin
            if (req_age >= 1) begin
                inst_addr_ok = 1'b1;
                resp_addr    = inst_addr;
                resp_wait    = 1;
                resp_cnt     = data_lat;
                req_age      = 0;
            end else begin
                req_age = req_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (fs_valid && ds_allowin) begin
                hpc_q.push_back(fs_pc);
                hinst_q.push_back(fs_inst);
                habn_q.push_back(fs_abnormal);
            end
            if (inst_req && inst_addr_ok)
                acc_q.push_back(inst_addr);
            if (inst_req && inst_addr[1:0] != 2'b00)
                odd_req++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle();
        ex_flush = 0; eret_flush = 0; br_taken = 0; j_taken = 0; jsrc = 0;
        epc = '0; br_target = '0; jr_target = '0; j_target = '0;
        ds_allowin = 1;
    endtask

    task automatic clear_logs();
        acc_q.delete(); hpc_q.delete(); hinst_q.delete(); habn_q.delete();
        odd_req = 0;
    endtask

    task automatic apply_reset();
        resetn = 0;
        drive_idle();
        data_lat = 0;
        repeat (2) @(posedge clk);
        #2;
        clear_logs();
        resetn = 1;
    endtask

    task automatic wait_acc(input logic [31:0] addr, input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk); #1;
            if (acc_q.size() > 0 && acc_q[$] == addr) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_acc: request for %h not accepted within %0d cycles", addr, limit);
        end
    endtask

    task automatic wait_hand(input int n, input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk); #1;
            if (hpc_q.size() >= n) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_hand: got %0d handoffs, required %0d", hpc_q.size(), n);
        end
    endtask

    task automatic wait_valid(input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk); #1;
            if (fs_valid) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_valid: fs_valid never rose within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        resetn = 0;
        drive_idle();
        #12;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", inst_req); end
        checks++; if (fs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", fs_valid); end
        checks++; if (fs_adel !== 1'b0) begin errors++; $display("FAIL rst_adel: got %b required 0", fs_adel); end
        checks++; if (fs_abnormal !== 1'b0) begin errors++; $display("FAIL rst_abn: got %b required 0", fs_abnormal); end
        checks++; if (fs_pc !== 32'h0) begin errors++; $display("FAIL rst_fs_pc: got %h required 0", fs_pc); end
        checks++; if (fs_inst !== 32'h0) begin errors++; $display("FAIL rst_fs_inst: got %h required 0", fs_inst); end
        checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL rst_pc: got %h required bfc00000", inst_addr); end
        @(posedge clk); #2;
        clear_logs();
        resetn = 1;
        @(posedge clk); #1;
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL boot_req: got %b required 1", inst_req); end
        checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL boot_addr: got %h required bfc00000", inst_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        apply_reset();
        wait_hand(3, 60);
        for (int i = 0; i < 3; i++) begin
            exp = 32'hbfc00000 + 32'(4 * i);
            checks++; if (acc_q[i] !== exp) begin errors++; $display("FAIL seq_addr%0d: got %h required %h", i, acc_q[i], exp); end
            checks++; if (hpc_q[i] !== exp) begin errors++; $display("FAIL seq_pc%0d: got %h required %h", i, hpc_q[i], exp); end
            checks++; if (hinst_q[i] !== inst_of(exp)) begin errors++; $display("FAIL seq_inst%0d: got %h required %h", i, hinst_q[i], inst_of(exp)); end
            checks++; if (habn_q[i] !== 1'b0) begin errors++; $display("FAIL seq_abn%0d: got %b required 0", i, habn_q[i]); end
        end
    endtask

    task automatic test_branch();
        int n08;
        apply_reset();
        wait_acc(32'hbfc00004, 40);
        @(posedge clk); #1;
        br_taken = 1; br_target = 32'hbfc00100;
        j_taken = 1;  j_target = 32'hbfc00200;
        @(posedge clk); #1;
        br_taken = 0; j_taken = 0;
        wait_hand(3, 60);
        n08 = 0;
        foreach (acc_q[i]) if (acc_q[i] == 32'hbfc00008) n08++;
        checks++; if (hpc_q[1] !== 32'hbfc00004) begin errors++; $display("FAIL br_slot_pc: got %h required bfc00004", hpc_q[1]); end
        checks++; if (acc_q[2] !== 32'hbfc00100) begin errors++; $display("FAIL br_next_addr: got %h required bfc00100", acc_q[2]); end
        checks++; if (hpc_q[2] !== 32'hbfc00100) begin errors++; $display("FAIL br_tgt_pc: got %h required bfc00100", hpc_q[2]); end
        checks++; if (n08 !== 0) begin errors++; $display("FAIL br_no_seq: got %0d requests to bfc00008 required 0", n08); end
    endtask

    task automatic test_jump();
        apply_reset();
        wait_acc(32'hbfc00000, 40);
        @(posedge clk); #1;
        j_taken = 1; jsrc = 1; jr_target = 32'hbfc00040; j_target = 32'hbfc00080;
        @(posedge clk); #1;
        j_taken = 0; jsrc = 0;
        wait_hand(2, 60);
        checks++; if (hpc_q[0] !== 32'hbfc00000) begin errors++; $display("FAIL jr_slot_pc: got %h required bfc00000", hpc_q[0]); end
        checks++; if (hpc_q[1] !== 32'hbfc00040) begin errors++; $display("FAIL jr_tgt_pc: got %h required bfc00040", hpc_q[1]); end
    endtask

    task automatic test_ex_flush();
        apply_reset();
        data_lat = 2;
        wait_acc(32'hbfc00008, 80);
        @(posedge clk); #1;
        ex_flush = 1;
        @(posedge clk); #1;
        ex_flush = 0;
        wait_hand(4, 80);
        checks++; if (acc_q[3] !== 32'hbfc00380) begin errors++; $display("FAIL exf_addr: got %h required bfc00380", acc_q[3]); end
        checks++; if (hpc_q[2] !== 32'hbfc00380) begin errors++; $display("FAIL exf_pc: got %h required bfc00380", hpc_q[2]); end
        checks++; if (hinst_q[2] !== inst_of(32'hbfc00380)) begin errors++; $display("FAIL exf_inst: got %h required %h", hinst_q[2], inst_of(32'hbfc00380)); end
        checks++; if (habn_q[2] !== 1'b1) begin errors++; $display("FAIL exf_abn: got %b required 1", habn_q[2]); end
        checks++; if (hpc_q[3] !== 32'hbfc00384) begin errors++; $display("FAIL exf_next_pc: got %h required bfc00384", hpc_q[3]); end
        checks++; if (habn_q[3] !== 1'b0) begin errors++; $display("FAIL exf_next_abn: got %b required 0", habn_q[3]); end
    endtask

    task automatic test_eret_misaligned();
        apply_reset();
        wait_acc(32'hbfc00000, 40);
        @(posedge clk); #1;
        eret_flush = 1; epc = 32'h80001002; ds_allowin = 0;
        @(posedge clk); #1;
        eret_flush = 0;
        wait_valid(20);
        checks++; if (fs_adel !== 1'b1) begin errors++; $display("FAIL eret_adel: got %b required 1", fs_adel); end
        checks++; if (fs_inst !== 32'h0) begin errors++; $display("FAIL eret_inst: got %h required 0", fs_inst); end
        checks++; if (fs_pc !== 32'h80001002) begin errors++; $display("FAIL eret_pc: got %h required 80001002", fs_pc); end
        checks++; if (fs_abnormal !== 1'b1) begin errors++; $display("FAIL eret_abn: got %b required 1", fs_abnormal); end
        checks++; if (odd_req !== 0) begin errors++; $display("FAIL eret_noreq: got %0d misaligned requests required 0", odd_req); end
        checks++; if (hpc_q.size() !== 0) begin errors++; $display("FAIL eret_drop: got %0d handoffs required 0", hpc_q.size()); end
        ds_allowin = 1;
    endtask

    task automatic test_flush_in_hold();
        apply_reset();
        ds_allowin = 0;
        wait_valid(40);
        checks++; if (fs_pc !== 32'hbfc00000) begin errors++; $display("FAIL hold_pc: got %h required bfc00000", fs_pc); end
        @(posedge clk); #1;
        ex_flush = 1; eret_flush = 1; epc = 32'h80000000;
        br_taken = 1; br_target = 32'hbfc00100; ds_allowin = 1;
        @(negedge clk);
        checks++; if (fs_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b required 0", fs_valid); end
        @(posedge clk); #1;
        ex_flush = 0; eret_flush = 0; br_taken = 0;
        wait_hand(2, 60);
        checks++; if (hpc_q[0] !== 32'hbfc00380) begin errors++; $display("FAIL hold_tgt: got %h required bfc00380", hpc_q[0]); end
        checks++; if (habn_q[0] !== 1'b1) begin errors++; $display("FAIL hold_abn: got %b required 1", habn_q[0]); end
        checks++; if (hpc_q[1] !== 32'hbfc00384) begin errors++; $display("FAIL hold_nobr: got %h required bfc00384", hpc_q[1]); end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        data_lat = 20;
        wait_acc(32'hbfc00000, 40);
        repeat (5) @(posedge clk);
        #3;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b required 0", inst_req); end
        resetn = 0;
        #1;
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b required 0", inst_req); end
        checks++; if (fs_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", fs_valid); end
        checks++; if (fs_pc !== 32'h0) begin errors++; $display("FAIL arst_fs_pc: got %h required 0", fs_pc); end
        checks++; if (fs_inst !== 32'h0) begin errors++; $display("FAIL arst_fs_inst: got %h required 0", fs_inst); end
        checks++; if (inst_addr !== 32'hbfc00000) begin errors++; $display("FAIL arst_pc: got %h required bfc00000", inst_addr); end
        repeat (5) @(posedge clk);
        data_lat = 0;
        #2;
        clear_logs();
        resetn = 1;
        wait_hand(1, 40);
        checks++; if (acc_q[0] !== 32'hbfc00000) begin errors++; $display("FAIL arst_first_addr: got %h required bfc00000", acc_q[0]); end
        checks++; if (hpc_q[0] !== 32'hbfc00000) begin errors++; $display("FAIL arst_first_pc: got %h required bfc00000", hpc_q[0]); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_ex_flush();
        test_eret_misaligned();
        test_flush_in_hold();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
